nibble_serial_add_ctrl: RTL
===========================

// Module: nibble_serial_add_ctrl
// PURPOSE
//  Sequencer that adds two wide operands using a single 4-bit full-adder slice,
//  one nibble per clock, LSB nibble first, carry held in a register between cycles.
//  Lets the team do 16-bit+ additions with one four-bit adder datapath instead of
//  a wide ripple chain. Start/busy/done handshake toward the requesting logic.
// PARAMETERS
//  NIBBLES  4  operand width in nibbles (operand width W = 4*NIBBLES); legal >= 1
// PORTS
//  clk    in   1    single clock, all state on rising edge
//  rst    in   1    synchronous, active-high reset
//  start  in   1    request; sampled only when busy=0
//  a      in   W    operand A, captured on accepted start
//  b      in   W    operand B, captured on accepted start
//  busy   out  1    high while nibbles are being processed (state RUN)
//  done   out  1    one-cycle pulse: sum/cout valid
//  sum    out  W    result, held until the next completion
//  cout   out  1    carry out of the MS nibble, held with sum
// BEHAVIOUR
//  - Reset (rst=1 at an edge): state<=IDLE, busy=0, done=0, sum=0, cout=0,
//    nibble index=0, carry reg=0, operand regs=0. Reset wins over all else.
//  - FSM states: IDLE, RUN, DONE.
//    IDLE: start=1 -> capture a,b; carry<=0; idx<=0; -> RUN. Else stay.
//    RUN : each cycle: {c,s} = a_reg[idx]+b_reg[idx]+carry (5-bit result);
//          work[idx]<=s; carry<=c; idx<=idx+1. When idx==NIBBLES-1 -> DONE,
//          sum<=work with nibble idx replaced by s, cout<=c.
//    DONE: done=1 for this cycle only; busy=0. start=1 here is accepted exactly
//          as in IDLE (back-to-back, -> RUN). Else -> IDLE.
//  - busy = (state==RUN). done = (state==DONE). Both registered-state decodes.
//  - Latency: start accepted at edge t -> RUN for NIBBLES cycles -> done high in
//    the cycle after edge t+NIBBLES; 16-bit add: done 5 cycles after start edge.
//  - start while busy=1 is ignored; a/b changes during RUN have no effect.
//  - sum/cout keep the previous result during RUN; update only on RUN->DONE.
//  - Arithmetic is modulo 2^W; overflow shows only on cout. Unsigned.
//  - idx width = clog2(NIBBLES), min 1; never exceeds NIBBLES-1.
//  - NIBBLES=1: RUN lasts one cycle; identical to a 4-bit add with registered out.
//  - rst mid-RUN aborts: no done pulse, sum/cout cleared to 0.
// TESTING
//  NIBBLES=4 unless noted; check busy/done timing on every case.
//  1. a=0x0003,b=0x0005,start 1 cycle -> busy 4 cycles, done pulse, sum=0x0008 cout=0
//  2. a=0xFFFF,b=0x0001 -> carry ripples all nibbles: sum=0x0000 cout=1
//  3. a=0xC7A9,b=0x0A57 -> sum=0xD200 cout=0; a=0x8000,b=0x8000 -> sum=0x0000 cout=1
//  4. start held high + a/b changed during RUN -> no restart, result of first
//     operands; start high in DONE cycle -> second op begins, busy next cycle
//  5. rst asserted in 2nd RUN cycle -> next cycle busy=0 done=0 sum=0 cout=0;
//     new start afterwards completes correctly
//  6. NIBBLES=1: a=0xF,b=0x1 -> done 2 cycles after start edge, sum=0x0 cout=1;
//     random regression vs a+b reference for NIBBLES=1,4,8

Source files
------------

// File: rtl/nibble_serial_add_ctrl.sv
// Serial adder: W = 4*NIBBLES operands summed one nibble per clock through a single
// 4-bit slice, LSB nibble first, with the carry held in a register between cycles.
module nibble_serial_add_ctrl #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NIBBLES-1:0]   a,
  input  logic [4*NIBBLES-1:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   sum,
  output logic                   cout
);

  localparam int W     = 4 * NIBBLES;
  localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  logic [W-1:0]     r_a;
  logic [W-1:0]     r_b;
  logic [W-1:0]     r_work;
  logic [W-1:0]     r_sum;
  logic             r_cout;
  logic             r_carry;
  logic [IDX_W-1:0] r_idx;

  logic [3:0]       w_a_nib;
  logic [3:0]       w_b_nib;
  logic [4:0]       w_add;
  logic [W-1:0]     w_work_nxt;

  // Slice input mux, the 4-bit adder itself, and the work word with the current nibble patched in
  always_comb begin
    w_a_nib    = 4'd0;
    w_b_nib    = 4'd0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_a_nib = r_a[4*i +: 4];
        w_b_nib = r_b[4*i +: 4];
      end
    end
    w_add      = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'd0, r_carry};
    w_work_nxt = r_work;
    for (int i = 0; i < NIBBLES; i++) begin
      if (r_idx == IDX_W'(i)) w_work_nxt[4*i +: 4] = w_add[3:0];
    end
  end

  // Sequencer: DONE accepts a new start just like IDLE so operations can run back to back
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_work  <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_carry <= 1'b0;
      r_idx   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          r_work  <= w_work_nxt;
          r_carry <= w_add[4];
          if (r_idx == LAST_IDX) begin
            r_idx   <= '0;
            r_sum   <= w_work_nxt;
            r_cout  <= w_add[4];
            r_state <= S_DONE;
          end else begin
            r_idx   <= r_idx + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
